// File: rtl/synth_seq_gen_if.sv
// Bundle of control inputs and slot outputs between the sweep sequencer and its consumers.
// Latency: none (wires only).
// Backpressure: none; consumers must accept every strobe.
//
// Ports grouped here:
//   trig, free_run, env_div, ovr_clr      : control into the sequencer
//   env_en, osc_en, xxxx, chan            : slot strobes and index out of the sequencer
//   run, xxxx_zero, xxxx_top, sweep_done  : status out of the sequencer
//   overrun                               : sticky trigger-during-sweep flag
interface synth_seq_gen_if #(
  parameter int V_WIDTH   = 5,
  parameter int E_WIDTH   = 3,
  parameter int CH_WIDTH  = 1,
  parameter int DIV_WIDTH = 8
);
  logic                         trig;
  logic                         free_run;
  logic [DIV_WIDTH-1:0]         env_div;
  logic                         ovr_clr;
  logic                         env_en;
  logic                         osc_en;
  logic [V_WIDTH+E_WIDTH-1:0]   xxxx;
  logic [CH_WIDTH-1:0]          chan;
  logic                         run;
  logic                         xxxx_zero;
  logic                         xxxx_top;
  logic                         sweep_done;
  logic                         overrun;

  // Sequencer side.
  modport master (
    input  trig, free_run, env_div, ovr_clr,
    output env_en, osc_en, xxxx, chan, run, xxxx_zero, xxxx_top, sweep_done, overrun
  );

  // Trigger source / pipeline side.
  modport slave (
    output trig, free_run, env_div, ovr_clr,
    input  env_en, osc_en, xxxx, chan, run, xxxx_zero, xxxx_top, sweep_done, overrun
  );
endinterface

// File: rtl/synth_seq_gen.sv
// Single-clock sweep sequencer: walks {voice, env} over all channels with programmable enable strobes.
// Latency: trig sampled high at edge E gives run=1 after edge E+3; first env_en env_div cycles later.
// Backpressure: none; strobes are free-running once a sweep starts, consumers must keep up.
//
// Ports:
//   AUDIO_CLK  : sole clock, rising edge
//   reset_reg  : synchronous active-high reset
//   bus        : synth_seq_gen_if.master (trig/free_run/env_div/ovr_clr in;
//                env_en/osc_en/xxxx/chan/run/xxxx_zero/xxxx_top/sweep_done/overrun out)
module synth_seq_gen #(
  parameter int VOICES         = 32,
  parameter int V_ENVS         = 8,
  parameter int V_WIDTH        = 5,
  parameter int E_WIDTH        = 3,
  parameter int SYNTH_CHANNELS = 1,
  parameter int CH_WIDTH       = 1,
  parameter int DIV_WIDTH      = 8,
  parameter int OSC_SHIFT      = 1
) (
  input  logic             AUDIO_CLK,
  input  logic             reset_reg,
  synth_seq_gen_if.master  bus
);

  localparam int                  IDX_W   = V_WIDTH + E_WIDTH;
  localparam logic [IDX_W-1:0]    IDX_TOP = IDX_W'(VOICES * V_ENVS - 1);
  localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(SYNTH_CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 trig_s1;
  logic                 trig_s2;
  logic                 trig_d;
  logic                 trig_rise;

  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] env_div_l;
  logic                 free_run_l;
  logic [IDX_W-1:0]     xxxx_q;
  logic [CH_WIDTH-1:0]  chan_q;
  logic                 sweep_done_q;
  logic                 overrun_q;

  logic                 start;
  logic                 restart;
  logic                 env_en;
  logic                 osc_en;
  logic                 sweep_end;
  logic                 idx_top;

  // ---------------------------------------------------------------------------
  // Trigger conditioning. The synchroniser and edge flop reset to 1 so a trig
  // held high across reset looks like "already high" rather than a new edge.
  // The rise is registered so the FSM sees it three edges after first sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge AUDIO_CLK) begin
    if (reset_reg) begin
      trig_s1   <= 1'b1;
      trig_s2   <= 1'b1;
      trig_d    <= 1'b1;
      trig_rise <= 1'b0;
    end else begin
      trig_s1   <= bus.trig;
      trig_s2   <= trig_s1;
      trig_d    <= trig_s2;
      trig_rise <= trig_s2 & ~trig_d;
    end
  end

  assign idx_top = (xxxx_q == IDX_TOP);

  // ---------------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge AUDIO_CLK) begin
    if (reset_reg) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes. A trigger in the sweep_done cycle is treated as an
  // overrun even in burst mode (where the FSM is already back in IDLE), so it
  // must not also start a sweep.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    restart   = 1'b0;
    env_en    = 1'b0;
    sweep_end = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise && !sweep_done_q) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        env_en    = (div_cnt == env_div_l);
        sweep_end = env_en && idx_top && (chan_q == CH_LAST);
        if (sweep_end) begin
          if (free_run_l) begin
            restart = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Oscillator strobe fires on every 2**OSC_SHIFT-th slot, aligned to index 0.
  generate
    if (OSC_SHIFT == 0) begin : g_osc_all
      assign osc_en = env_en;
    end else begin : g_osc_div
      assign osc_en = env_en && (xxxx_q[OSC_SHIFT-1:0] == '0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Datapath. The counter restarts at 0 on every env_en, so the sweep_done cycle
  // of a free-run restart is already the first count of the next spacing and the
  // boundary gap matches the intra-sweep gap. The index wraps to 0 naturally on
  // the last slot, leaving both modes at xxxx=0, chan=0 after a sweep.
  // ---------------------------------------------------------------------------
  always_ff @(posedge AUDIO_CLK) begin
    if (reset_reg) begin
      div_cnt      <= '0;
      env_div_l    <= '0;
      free_run_l   <= 1'b0;
      xxxx_q       <= '0;
      chan_q       <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sweep_done_q <= sweep_end;

      if (start || restart) begin
        env_div_l  <= bus.env_div;
        free_run_l <= bus.free_run;
      end

      if (start) begin
        div_cnt <= '0;
      end else if (state == RUN) begin
        div_cnt <= env_en ? '0 : div_cnt + DIV_WIDTH'(1);
      end

      if (start) begin
        xxxx_q <= '0;
        chan_q <= '0;
      end else if (env_en) begin
        if (idx_top) begin
          xxxx_q <= '0;
          chan_q <= (chan_q == CH_LAST) ? '0 : chan_q + CH_WIDTH'(1);
        end else begin
          xxxx_q <= xxxx_q + IDX_W'(1);
        end
      end

      // Set beats clear when both happen in one cycle.
      if (trig_rise && ((state == RUN) || sweep_done_q)) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.env_en     = env_en;
  assign bus.osc_en     = osc_en;
  assign bus.xxxx       = xxxx_q;
  assign bus.chan       = chan_q;
  assign bus.run        = (state == RUN);
  assign bus.xxxx_zero  = (xxxx_q == '0);
  assign bus.xxxx_top   = idx_top;
  assign bus.sweep_done = sweep_done_q;
  assign bus.overrun    = overrun_q;

endmodule
